// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel (AR/R) between the instruction-fetch and data requesters.
// Bursts are granted round-robin, one outstanding at a time; R beats are routed to the
// owner with a beat index, and an in-flight instruction burst can be dropped on flush.
module axi_read_arbiter (
  input  logic        clk,
  input  logic        resetn,
  // instruction requester
  input  logic        inst_arvalid,
  input  logic [31:0] inst_araddr,
  input  logic [3:0]  inst_arlen,
  input  logic [2:0]  inst_arsize,
  input  logic        inst_flush,
  output logic        inst_arready,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  output logic [3:0]  inst_rbeat,
  // data requester
  input  logic        data_arvalid,
  input  logic [31:0] data_araddr,
  input  logic [3:0]  data_arlen,
  input  logic [2:0]  data_arsize,
  output logic        data_arready,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  output logic [3:0]  data_rbeat,
  // AXI master read channel
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        id_err
);

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned SIZE_W = 3;

  localparam logic [ID_W-1:0] INST_ID = ID_W'(0);
  localparam logic [ID_W-1:0] DATA_ID = ID_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
  } ar_t;

  state_t            state_q, state_d;
  ar_t               ar_q, ar_d;
  logic              owner_data_q;   // 1: data owns the channel, 0: instruction
  logic              last_data_q;    // 1: most recent grant went to data
  logic              discard_q;
  logic              post_reset_q;   // no grant since reset: R beats seen in IDLE are stale
  logic              id_err_q;
  logic [LEN_W-1:0]  beat_q;

  logic inst_req_c, data_req_c;
  logic grant_c, grant_data_c;
  logic beat_acc_c, beat_bad_c, stale_c;
  logic flush_hit_c, fwd_c;
  logic unused_rresp;

  assign inst_req_c   = inst_arvalid & ~inst_flush;
  assign data_req_c   = data_arvalid;
  assign unused_rresp = ^m_rresp;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, arbitration and channel handshakes
  always_comb begin
    state_d      = state_q;
    grant_c      = 1'b0;
    grant_data_c = 1'b0;
    beat_acc_c   = 1'b0;
    beat_bad_c   = 1'b0;
    stale_c      = 1'b0;
    inst_arready = 1'b0;
    data_arready = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    case (state_q)
      S_IDLE: begin
        stale_c = post_reset_q & m_rvalid;
        if (inst_req_c || data_req_c) begin
          grant_c      = 1'b1;
          grant_data_c = data_req_c & (~inst_req_c | ~last_data_q);
          inst_arready = ~grant_data_c;
          data_arready = grant_data_c;
          state_d      = S_ADDR;
        end
      end
      S_ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = S_DATA;
      end
      S_DATA: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          if (m_rid == ar_q.id) begin
            beat_acc_c = 1'b1;
            if (m_rlast) state_d = S_IDLE;
          end else begin
            beat_bad_c = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AR payload of the winning requester
  always_comb begin
    if (grant_data_c) ar_d = '{id: DATA_ID, addr: data_araddr, len: data_arlen, size: data_arsize};
    else              ar_d = '{id: INST_ID, addr: inst_araddr, len: inst_arlen, size: inst_arsize};
  end

  // Latched AR fields, ownership, beat counter, discard and error flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_q         <= '0;
      owner_data_q <= 1'b1;
      last_data_q  <= 1'b1;
      discard_q    <= 1'b0;
      post_reset_q <= 1'b1;
      id_err_q     <= 1'b0;
      beat_q       <= '0;
    end else begin
      id_err_q <= id_err_q | beat_bad_c | stale_c;
      if (grant_c) begin
        ar_q         <= ar_d;
        owner_data_q <= grant_data_c;
        last_data_q  <= grant_data_c;
        discard_q    <= 1'b0;
        post_reset_q <= 1'b0;
        beat_q       <= '0;
      end else begin
        if (state_q != S_IDLE && flush_hit_c) discard_q <= 1'b1;
        if (beat_acc_c) beat_q <= beat_q + LEN_W'(1);
      end
    end
  end

  // R routing: a flush in the same cycle already hides the instruction beat
  assign flush_hit_c = inst_flush & ~owner_data_q;
  assign fwd_c       = beat_acc_c & ~discard_q & ~flush_hit_c;

  assign inst_rvalid = fwd_c & ~owner_data_q;
  assign data_rvalid = fwd_c &  owner_data_q;
  assign inst_rlast  = inst_rvalid & m_rlast;
  assign data_rlast  = data_rvalid & m_rlast;
  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;
  assign inst_rbeat  = owner_data_q ? '0 : beat_q;
  assign data_rbeat  = owner_data_q ? beat_q : '0;

  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = 2'b01;
  assign id_err    = id_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: arbitration, AR stability, routing, flush, ID errors, reset.
module tb_axi_read_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_arvalid, inst_flush, inst_arready, inst_rvalid, inst_rlast;
  logic [31:0] inst_araddr, inst_rdata;
  logic [3:0]  inst_arlen, inst_rbeat;
  logic [2:0]  inst_arsize;
  logic        data_arvalid, data_arready, data_rvalid, data_rlast;
  logic [31:0] data_araddr, data_rdata;
  logic [3:0]  data_arlen, data_rbeat;
  logic [2:0]  data_arsize;
  logic [3:0]  m_arid, m_arlen, m_rid;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready, id_err;

  int checks;
  int failures;

  axi_read_arbiter dut (
    .clk(clk), .resetn(resetn),
    .inst_arvalid(inst_arvalid), .inst_araddr(inst_araddr), .inst_arlen(inst_arlen),
    .inst_arsize(inst_arsize), .inst_flush(inst_flush), .inst_arready(inst_arready),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rlast(inst_rlast),
    .inst_rbeat(inst_rbeat),
    .data_arvalid(data_arvalid), .data_araddr(data_araddr), .data_arlen(data_arlen),
    .data_arsize(data_arsize), .data_arready(data_arready), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_rlast(data_rlast), .data_rbeat(data_rbeat),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .id_err(id_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave side: accept AR then return n beats with the given ID
  task automatic finish_burst(input logic [3:0] id, input int n);
    @(negedge clk); m_arready = 1'b1;
    @(negedge clk); m_arready = 1'b0;
    for (int i = 0; i < n; i++) begin
      m_rvalid = 1'b1; m_rid = id; m_rdata = 32'hA5A5_0000 + i; m_rlast = (i == n - 1);
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({inst_arready, data_arready, inst_rvalid, data_rvalid, inst_rlast, data_rlast, m_arvalid, m_rready} !== 8'h00) begin
      failures++; $display("FAIL rst_ctrl got=%b exp=00000000",
        {inst_arready, data_arready, inst_rvalid, data_rvalid, inst_rlast, data_rlast, m_arvalid, m_rready});
    end
    checks++;
    if ({m_arid, m_araddr, m_arlen, m_arsize} !== 43'h0) begin
      failures++; $display("FAIL rst_ar got=%h exp=0", {m_arid, m_araddr, m_arlen, m_arsize});
    end
    checks++;
    if ({inst_rbeat, data_rbeat, id_err} !== 9'h0) begin
      failures++; $display("FAIL rst_beat_err got=%h exp=0", {inst_rbeat, data_rbeat, id_err});
    end
    checks++;
    if (m_arburst !== 2'b01) begin
      failures++; $display("FAIL arburst got=%b exp=01", m_arburst);
    end
    @(negedge clk); resetn = 1'b1;
  endtask

  task automatic test_round_robin;
    logic        exp_data;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    for (int k = 0; k < 3; k++) begin
      exp_data = (k == 1);
      exp_id   = exp_data ? 4'd1 : 4'd0;
      exp_addr = exp_data ? 32'h2000_0000 + k : 32'h1000_0000 + k;
      @(negedge clk);
      inst_arvalid = 1'b1; data_arvalid = 1'b1;
      inst_araddr = 32'h1000_0000 + k; data_araddr = 32'h2000_0000 + k;
      inst_arlen = 4'd0; data_arlen = 4'd0;
      #1;
      checks++;
      if ({inst_arready, data_arready} !== {~exp_data, exp_data}) begin
        failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, {inst_arready, data_arready}, {~exp_data, exp_data});
      end
      @(negedge clk);
      inst_arvalid = 1'b0; data_arvalid = 1'b0;
      #1;
      checks++;
      if ({m_arvalid, m_arid, m_araddr} !== {1'b1, exp_id, exp_addr}) begin
        failures++; $display("FAIL rr_ar%0d got=%h exp=%h", k, {m_arvalid, m_arid, m_araddr}, {1'b1, exp_id, exp_addr});
      end
      checks++;
      if ({inst_arready, data_arready} !== 2'b00) begin
        failures++; $display("FAIL rr_pulse%0d got=%b exp=00", k, {inst_arready, data_arready});
      end
      finish_burst(exp_id, 1);
    end
  endtask

  task automatic test_single_inst;
    @(negedge clk);
    inst_arvalid = 1'b1; inst_araddr = 32'hBFC0_0020; inst_arlen = 4'd7; inst_arsize = 3'd2;
    #1;
    checks++;
    if ({inst_arready, m_arvalid} !== 2'b10) begin
      failures++; $display("FAIL si_grant got=%b exp=10", {inst_arready, m_arvalid});
    end
    @(negedge clk); inst_arvalid = 1'b0;
    #1;
    checks++;
    if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsize} !== {1'b1, 4'd0, 32'hBFC0_0020, 4'd7, 3'd2}) begin
      failures++; $display("FAIL si_ar1 got=%h exp=%h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize},
        {1'b1, 4'd0, 32'hBFC0_0020, 4'd7, 3'd2});
    end
    @(negedge clk); m_arready = 1'b1;
    #1;
    checks++;
    if ({m_arvalid, m_arid, m_araddr, m_arlen, m_arsize} !== {1'b1, 4'd0, 32'hBFC0_0020, 4'd7, 3'd2}) begin
      failures++; $display("FAIL si_ar2 got=%h exp=%h", {m_arvalid, m_arid, m_araddr, m_arlen, m_arsize},
        {1'b1, 4'd0, 32'hBFC0_0020, 4'd7, 3'd2});
    end
    @(negedge clk); m_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'h1234_0000 + i; m_rlast = (i == 7);
      #1;
      checks++;
      if ({inst_rvalid, inst_rlast, inst_rbeat} !== {1'b1, (i == 7), 4'(i)}) begin
        failures++; $display("FAIL si_beat%0d got=%b exp=%b", i, {inst_rvalid, inst_rlast, inst_rbeat}, {1'b1, (i == 7), 4'(i)});
      end
      checks++;
      if (inst_rdata !== 32'h1234_0000 + i) begin
        failures++; $display("FAIL si_rdata%0d got=%h exp=%h", i, inst_rdata, 32'h1234_0000 + i);
      end
      checks++;
      if ({data_rvalid, data_rbeat, m_rready} !== {1'b0, 4'd0, 1'b1}) begin
        failures++; $display("FAIL si_other%0d got=%b exp=000001", i, {data_rvalid, data_rbeat, m_rready});
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++;
    if ({m_rready, m_arvalid, inst_rvalid} !== 3'b000) begin
      failures++; $display("FAIL si_idle got=%b exp=000", {m_rready, m_arvalid, inst_rvalid});
    end
    // a stray beat while idle is neither consumed nor an ID error
    @(negedge clk); m_rvalid = 1'b1; m_rid = 4'd5;
    #1;
    checks++;
    if ({m_rready, inst_rvalid, data_rvalid} !== 3'b000) begin
      failures++; $display("FAIL si_stray got=%b exp=000", {m_rready, inst_rvalid, data_rvalid});
    end
    @(negedge clk); m_rvalid = 1'b0;
    #1;
    checks++;
    if (id_err !== 1'b0) begin
      failures++; $display("FAIL si_stray_err got=%b exp=0", id_err);
    end
  endtask

  task automatic test_drop_arvalid;
    @(negedge clk);
    data_arvalid = 1'b1; data_araddr = 32'h8000_1000; data_arlen = 4'd3; data_arsize = 3'd2;
    #1;
    checks++;
    if ({inst_arready, data_arready} !== 2'b01) begin
      failures++; $display("FAIL drop_grant got=%b exp=01", {inst_arready, data_arready});
    end
    @(negedge clk);
    data_arvalid = 1'b0; data_araddr = 32'hDEAD_BEEF; data_arlen = 4'hF;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) m_arready = 1'b1;
      #1;
      checks++;
      if ({m_arvalid, m_arid, m_araddr, m_arlen} !== {1'b1, 4'd1, 32'h8000_1000, 4'd3}) begin
        failures++; $display("FAIL drop_ar%0d got=%h exp=%h", c, {m_arvalid, m_arid, m_araddr, m_arlen},
          {1'b1, 4'd1, 32'h8000_1000, 4'd3});
      end
      @(negedge clk);
    end
    m_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'h5500_0000 + i; m_rlast = (i == 3); inst_flush = (i == 1);
      #1;
      checks++;
      if ({data_rvalid, data_rbeat, data_rlast} !== {1'b1, 4'(i), (i == 3)}) begin
        failures++; $display("FAIL drop_beat%0d got=%b exp=%b", i, {data_rvalid, data_rbeat, data_rlast}, {1'b1, 4'(i), (i == 3)});
      end
      checks++;
      if ({inst_rvalid, inst_rbeat} !== 5'b0) begin
        failures++; $display("FAIL drop_inst%0d got=%b exp=00000", i, {inst_rvalid, inst_rbeat});
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; inst_flush = 1'b0;
  endtask

  task automatic test_flush;
    @(negedge clk);
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_0100; inst_arlen = 4'd7;
    #1;
    checks++;
    if (inst_arready !== 1'b1) begin
      failures++; $display("FAIL fl_grant got=%b exp=1", inst_arready);
    end
    @(negedge clk); inst_arvalid = 1'b0;
    @(negedge clk); m_arready = 1'b1;
    @(negedge clk); m_arready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'h7700_0000 + i; m_rlast = (i == 7); inst_flush = (i == 3);
      #1;
      checks++;
      if ({inst_rvalid, m_rready} !== {(i < 3), 1'b1}) begin
        failures++; $display("FAIL fl_beat%0d got=%b exp=%b", i, {inst_rvalid, m_rready}, {(i < 3), 1'b1});
      end
      @(negedge clk);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++;
    if ({m_rready, m_arvalid} !== 2'b00) begin
      failures++; $display("FAIL fl_idle got=%b exp=00", {m_rready, m_arvalid});
    end
  endtask

  task automatic test_wrong_id;
    @(negedge clk);
    data_arvalid = 1'b1; data_araddr = 32'h0000_3000; data_arlen = 4'd1;
    #1;
    checks++;
    if (data_arready !== 1'b1) begin
      failures++; $display("FAIL wid_grant got=%b exp=1", data_arready);
    end
    @(negedge clk); data_arvalid = 1'b0;
    @(negedge clk); m_arready = 1'b1;
    @(negedge clk); m_arready = 1'b0;
    m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b0; m_rdata = 32'hCAFE_0000;
    #1;
    checks++;
    if ({data_rvalid, data_rbeat} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL wid_first got=%b exp=10000", {data_rvalid, data_rbeat});
    end
    @(negedge clk); m_rid = 4'd2; m_rlast = 1'b1;
    #1;
    checks++;
    if ({data_rvalid, data_rbeat, m_rready, id_err} !== {1'b0, 4'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL wid_bad got=%b exp=0000110", {data_rvalid, data_rbeat, m_rready, id_err});
    end
    @(negedge clk); m_rid = 4'd1;
    #1;
    checks++;
    if ({data_rvalid, data_rlast, data_rbeat, id_err} !== {1'b1, 1'b1, 4'd1, 1'b1}) begin
      failures++; $display("FAIL wid_last got=%b exp=1100011", {data_rvalid, data_rlast, data_rbeat, id_err});
    end
    @(negedge clk); m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    checks++;
    if ({m_rready, id_err} !== 2'b01) begin
      failures++; $display("FAIL wid_sticky got=%b exp=01", {m_rready, id_err});
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    inst_arvalid = 1'b1; inst_araddr = 32'h0000_0400; inst_arlen = 4'd7;
    @(negedge clk); inst_arvalid = 1'b0;
    @(negedge clk); m_arready = 1'b1;
    @(negedge clk); m_arready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'h9900_0000 + i; m_rlast = 1'b0;
      @(negedge clk);
    end
    m_rdata = 32'h9900_0004; resetn = 1'b0;
    #1;
    checks++;
    if ({inst_rvalid, inst_rlast, inst_rbeat, m_rready, m_arvalid, id_err, inst_arready} !== 10'h0) begin
      failures++; $display("FAIL rm_ctrl got=%b exp=0", {inst_rvalid, inst_rlast, inst_rbeat, m_rready, m_arvalid, id_err, inst_arready});
    end
    checks++;
    if ({m_arid, m_araddr, m_arlen, m_arsize} !== 43'h0) begin
      failures++; $display("FAIL rm_ar got=%h exp=0", {m_arid, m_araddr, m_arlen, m_arsize});
    end
    @(negedge clk); resetn = 1'b1; m_rdata = 32'h9900_0005;
    #1;
    checks++;
    if ({m_rready, inst_rvalid, id_err} !== 3'b000) begin
      failures++; $display("FAIL rm_stale got=%b exp=000", {m_rready, inst_rvalid, id_err});
    end
    @(negedge clk); m_rvalid = 1'b0;
    #1;
    checks++;
    if (id_err !== 1'b1) begin
      failures++; $display("FAIL rm_stale_err got=%b exp=1", id_err);
    end
    @(negedge clk); inst_arvalid = 1'b1; data_arvalid = 1'b1;
    #1;
    checks++;
    if ({inst_arready, data_arready} !== 2'b10) begin
      failures++; $display("FAIL rm_regrant got=%b exp=10", {inst_arready, data_arready});
    end
    @(negedge clk); inst_arvalid = 1'b0; data_arvalid = 1'b0;
    finish_burst(4'd0, 1);
  endtask

  initial begin
    checks = 0; failures = 0;
    resetn = 1'b0;
    inst_arvalid = 1'b0; inst_araddr = '0; inst_arlen = '0; inst_arsize = '0; inst_flush = 1'b0;
    data_arvalid = 1'b0; data_araddr = '0; data_arlen = '0; data_arsize = '0;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    test_reset;
    test_round_robin;
    test_single_inst;
    test_drop_arvalid;
    test_flush;
    test_wrong_id;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
